// File: rtl/mem_access_unit.sv
// MEM stage of the pipelined MIPS: data-memory req/ready port, branch resolve and the MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to reject non-word-aligned accesses and expose the sticky misalign_err port.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        zero_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] read_data2_in,
    input  logic [4:0]  write_reg_in,
    input  logic [31:0] branch_target_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        flush,
    output logic        bus_error,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      captured;
    logic             acc;
    logic             misaligned;
    logic             start;

    assign acc = mem_read_in | mem_write_in;
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = acc & (alu_result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign start = acc & ~misaligned;

    // The stall must be visible in the same cycle the access is seen so EX/MEM holds the instruction.
    assign stall     = (state == BUSY) | ((state == IDLE) & start);
    assign pc_src    = branch_in & zero_in & (state == IDLE);
    assign pc_branch = branch_target_in;
    assign flush     = pc_src;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            captured       <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            bus_error      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_err   <= 1'b0;
`endif
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            write_reg_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req       <= 1'b1;
                        dmem_we        <= mem_write_in;
                        dmem_addr      <= alu_result_in;
                        dmem_wdata     <= read_data2_in;
                        wait_cnt       <= '0;
                        state          <= BUSY;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 1'b0;
                        read_data_out  <= '0;
                        alu_result_out <= '0;
                        write_reg_out  <= '0;
                    end else begin
                        reg_write_out  <= reg_write_in & ~misaligned;
                        mem_to_reg_out <= mem_to_reg_in;
                        read_data_out  <= '0;
                        alu_result_out <= alu_result_in;
                        write_reg_out  <= write_reg_in;
`ifdef MEM_ALIGN_CHECK_EN
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    reg_write_out  <= 1'b0;
                    mem_to_reg_out <= 1'b0;
                    read_data_out  <= '0;
                    alu_result_out <= '0;
                    write_reg_out  <= '0;
                    // A ready arriving on the last allowed cycle still completes normally.
                    if (dmem_ready) begin
                        captured <= dmem_we ? 32'h0 : dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus_error <= 1'b1;
                        captured  <= '0;
                        dmem_req  <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    reg_write_out  <= reg_write_in;
                    mem_to_reg_out <= mem_to_reg_in;
                    read_data_out  <= captured;
                    alu_result_out <= alu_result_in;
                    write_reg_out  <= write_reg_in;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: MEM/WB results are predicted into a scoreboard queue and checked on completion.
// Exercises the MEM_ALIGN_CHECK_EN port and checks only when that macro is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in, zero_in;
    logic [31:0] alu_result_in, read_data2_in, branch_target_in;
    logic [4:0]  write_reg_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pc_src, flush, bus_error;
    logic [31:0] pc_branch;
    logic        reg_write_out, mem_to_reg_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  write_reg_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } wb_t;

    wb_t sb[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  stalls;
    int  req_cycles;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .zero_in(zero_in),
        .alu_result_in(alu_result_in), .read_data2_in(read_data2_in), .write_reg_in(write_reg_in),
        .branch_target_in(branch_target_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch), .flush(flush), .bus_error(bus_error),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .write_reg_out(write_reg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] wreg,
                                 input logic rw, input logic m2r);
        mem_read_in   = rd;
        mem_write_in  = wr;
        alu_result_in = addr;
        read_data2_in = wdata;
        write_reg_in  = wreg;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        branch_in        = 1'b0;
        zero_in          = 1'b0;
        branch_target_in = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWb(input logic rw, input logic m2r, input logic [31:0] rd,
                            input logic [31:0] alu, input logic [4:0] wr);
        wb_t e;
        e = '{rw: rw, m2r: m2r, rd: rd, alu: alu, wr: wr};
        sb.push_back(e);
    endtask

    task automatic compareMemWb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, ".reg_write"},  32'(reg_write_out),  32'(e.rw));
            checkOutput({tag, ".mem_to_reg"}, 32'(mem_to_reg_out), 32'(e.m2r));
            checkOutput({tag, ".read_data"},  read_data_out,       e.rd);
            checkOutput({tag, ".alu_result"}, alu_result_out,      e.alu);
            checkOutput({tag, ".write_reg"},  32'(write_reg_out),  32'(e.wr));
        end
    endtask

    // Walks an access already driven in IDLE through BUSY, supplying ready after ready_after wait cycles.
    task automatic runAccess(input string tag, input int ready_after, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic exp_we,
                             output int n_stall, output int n_req);
        int guard;
        n_stall = 0;
        n_req   = 0;
        guard   = 0;
        while (stall === 1'b1 && guard < 40) begin
            n_stall++;
            if (dmem_req === 1'b1) begin
                n_req++;
                checkOutput({tag, ".addr"},  dmem_addr,  exp_addr);
                checkOutput({tag, ".wdata"}, dmem_wdata, exp_wdata);
                checkOutput({tag, ".we"},    32'(dmem_we), 32'(exp_we));
                checkOutput({tag, ".bubble"}, 32'(reg_write_out), 32'd0);
            end
            dmem_ready = (dmem_req === 1'b1) && (n_req - 1 == ready_after);
            dmem_rdata = dmem_ready ? rdata : 32'hFFFF_FFFF;
            step();
            guard++;
        end
        dmem_ready = 1'b0;
        dmem_rdata = 32'hFFFF_FFFF;
        if (guard >= 40) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s.hang: observed stall for %0d cycles expected release", tag, guard);
        end
        checkOutput({tag, ".req_done"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'hFFFF_FFFF;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.req",       32'(dmem_req),      32'd0);
        checkOutput("rst.bus_error", 32'(bus_error),     32'd0);
        checkOutput("rst.reg_write", 32'(reg_write_out), 32'd0);
        checkOutput("rst.read_data", read_data_out,      32'd0);
        checkOutput("rst.stall",     32'(stall),         32'd0);
        reset = 1'b1;

        // Branch resolution is purely combinational in IDLE.
        branch_in = 1'b1; zero_in = 1'b1; branch_target_in = 32'h100;
        #1;
        checkOutput("br.pc_src",    32'(pc_src), 32'd1);
        checkOutput("br.flush",     32'(flush),  32'd1);
        checkOutput("br.pc_branch", pc_branch,   32'h100);
        checkOutput("br.stall",     32'(stall),  32'd0);
        zero_in = 1'b0;
        #1;
        checkOutput("br.nz_pc_src", 32'(pc_src), 32'd0);
        checkOutput("br.nz_flush",  32'(flush),  32'd0);
        clearInputs();
        step();

        applyStimulus(1'b0, 1'b0, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0);
        expectWb(1'b1, 1'b0, 32'h0, 32'h55, 5'd7);
        #1;
        checkOutput("alu.stall", 32'(stall), 32'd0);
        step();
        compareMemWb("alu");

        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 5'd5, 1'b1, 1'b1);
        expectWb(1'b1, 1'b1, 32'h1234_5678, 32'h40, 5'd5);
        #1;
        runAccess("ld", 0, 32'h1234_5678, 32'h40, 32'h0, 1'b0, stalls, req_cycles);
        checkOutput("ld.stalls", 32'(stalls),     32'd2);
        checkOutput("ld.busy",   32'(req_cycles), 32'd1);
        step();
        compareMemWb("ld");

        applyStimulus(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);
        expectWb(1'b0, 1'b0, 32'h0, 32'h80, 5'd0);
        #1;
        runAccess("st", 3, 32'h0BAD_0BAD, 32'h80, 32'hCAFE_F00D, 1'b1, stalls, req_cycles);
        checkOutput("st.stalls",    32'(stalls),     32'd5);
        checkOutput("st.busy",      32'(req_cycles), 32'd4);
        checkOutput("st.bus_error", 32'(bus_error),  32'd0);
        step();
        compareMemWb("st");

        applyStimulus(1'b1, 1'b0, 32'hC0, 32'h0, 5'd9, 1'b1, 1'b1);
        expectWb(1'b1, 1'b1, 32'h0, 32'hC0, 5'd9);
        #1;
        runAccess("to", 100, 32'h7777_7777, 32'hC0, 32'h0, 1'b0, stalls, req_cycles);
        checkOutput("to.stalls",    32'(stalls),     32'd5);
        checkOutput("to.busy",      32'(req_cycles), 32'd4);
        checkOutput("to.bus_error", 32'(bus_error),  32'd1);
        step();
        compareMemWb("to");

        applyStimulus(1'b0, 1'b0, 32'h99, 32'h0, 5'd2, 1'b1, 1'b0);
        expectWb(1'b1, 1'b0, 32'h0, 32'h99, 5'd2);
        step();
        compareMemWb("alu2");
        checkOutput("to.sticky", 32'(bus_error), 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
        applyStimulus(1'b1, 1'b0, 32'h42, 32'h0, 5'd3, 1'b1, 1'b1);
        expectWb(1'b0, 1'b1, 32'h0, 32'h42, 5'd3);
        #1;
        checkOutput("mis.stall", 32'(stall), 32'd0);
        step();
        checkOutput("mis.req", 32'(dmem_req),     32'd0);
        checkOutput("mis.err", 32'(misalign_err), 32'd1);
        compareMemWb("mis");
        clearInputs();
        step();
        checkOutput("mis.sticky", 32'(misalign_err), 32'd1);
`endif

        // Reset asserted while a load is waiting on memory.
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1, 1'b1);
        step();
        checkOutput("rb.busy_req", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("rb.req",       32'(dmem_req),      32'd0);
        checkOutput("rb.stall",     32'(stall),         32'd0);
        checkOutput("rb.bus_error", 32'(bus_error),     32'd0);
        checkOutput("rb.reg_write", 32'(reg_write_out), 32'd0);
        checkOutput("rb.read_data", read_data_out,      32'd0);
        checkOutput("rb.alu",       alu_result_out,     32'd0);
        checkOutput("rb.write_reg", 32'(write_reg_out), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("rb.misalign", 32'(misalign_err), 32'd0);
`endif
        dmem_ready = 1'b1;
        dmem_rdata = 32'hABCD_0123;
        step();
        dmem_ready = 1'b0;
        checkOutput("rb.idle_req",  32'(dmem_req),      32'd0);
        checkOutput("rb.no_write",  32'(reg_write_out), 32'd0);
        checkOutput("rb.no_rdata",  read_data_out,      32'd0);
        checkOutput("sb.drained",   32'(sb.size()),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller of the pipelined MIPS; consumes the EX/MEM register outputs.
- Drives a req/ready data-memory port and resolves branches (pc_src, flush).
- Stalls the upstream pipeline while an access is in flight.
- Owns the MEM/WB pipeline register feeding writeback.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles without dmem_ready before abort (>=1)
CNT_W, 5, timeout counter width (2^CNT_W > TIMEOUT_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low
reg_write_in  in  1  WB control from EX/MEM
mem_to_reg_in  in  1  WB select from EX/MEM
branch_in  in  1  branch instruction in MEM
mem_read_in  in  1  load in MEM
mem_write_in  in  1  store in MEM
zero_in  in  1  ALU zero flag
alu_result_in  in  32  address / ALU result
read_data2_in  in  32  store data
write_reg_in  in  5  destination register
branch_target_in  in  32  branch target PC
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, registered
dmem_addr  out  32  registered address
dmem_wdata  out  32  registered store data
dmem_ready  in  1  memory completes access this cycle
dmem_rdata  in  32  load data, valid with dmem_ready
stall  out  1  hold IF/ID, ID/EX, EX/MEM (drive their enable low)
pc_src  out  1  take branch
pc_branch  out  32  branch target to PC mux
flush  out  1  clear IF/ID, ID/EX, EX/MEM
bus_error  out  1  sticky, set on timeout
reg_write_out  out  1  MEM/WB
mem_to_reg_out  out  1  MEM/WB
read_data_out  out  32  MEM/WB load data
alu_result_out  out  32  MEM/WB
write_reg_out  out  5  MEM/WB

Behaviour:
- Reset is sampled at the posedge while low. Effects: state IDLE; all registered outputs and the counter are 0; bus_error is cleared.
- Reset during BUSY aborts the access. dmem_req is 0 after that edge and no MEM/WB write happens.
- acc = mem_read_in | mem_write_in. If both are set, the access is treated as a write.
- IDLE:
  - acc=0: stall=0 and MEM/WB loads passthrough every cycle, with read_data_out=0.
  - acc=1: stall=1 combinationally. Load dmem_req=1, dmem_we=mem_write_in, and addr/wdata. Clear the counter, go to BUSY, and load a bubble into MEM/WB (reg_write_out=0, other fields 0).
- BUSY:
  - stall=1; request fields are held stable; MEM/WB loads a bubble each cycle.
  - dmem_ready=1: capture dmem_rdata (write: capture 0), drop dmem_req, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: set bus_error, capture 0, drop dmem_req, go to DONE.
- DONE:
  - stall=0. MEM/WB loads the EX/MEM fields with read_data_out = captured data.
  - EX/MEM advances on the same edge; go to IDLE.
- Latency: access with dmem_ready on the first BUSY cycle = 3 cycles in MEM (IDLE, BUSY, DONE), i.e. 2 stall cycles. Each extra wait cycle adds one.
- Branch: pc_src = branch_in & zero_in & (state==IDLE), combinational. pc_branch = branch_target_in. flush = pc_src. Branches never stall.
- dmem_ready in IDLE/DONE is ignored.
- All pipeline inputs are zero during an EX/MEM bubble, so acc=0 and no access starts.

Optional Feature:
MEM_ALIGN_CHECK_EN.
- Defined: an access with alu_result_in[1:0] != 0 never leaves IDLE. No dmem_req is issued, stall=0, and MEM/WB loads with reg_write_out=0. Output port misalign_err (1 bit, sticky, cleared by reset) is set.
- Undefined: no check; the port is absent; low address bits pass through unchanged.

Test Plan:
- Reset low 2 cycles mid-BUSY -> dmem_req=0, state IDLE, all MEM/WB outputs 0, bus_error 0.
- Load addr 0x40, dmem_ready first BUSY cycle, rdata 0x12345678, write_reg 5 -> stall high exactly 2 cycles; next MEM/WB read_data_out=0x12345678, write_reg_out=5, reg_write_out=1.
- Store addr 0x80, wdata 0xCAFEF00D, ready after 3 wait cycles -> dmem_we=1, addr/wdata stable all 4 BUSY cycles, stall 5 cycles, reg_write_out=0.
- No ready, TIMEOUT_CYCLES=4 -> dmem_req drops after 4 BUSY cycles, bus_error=1 and stays set, read_data_out=0.
- branch_in=1, zero_in=1, target 0x100 -> pc_src=1, flush=1, pc_branch=0x100 same cycle, stall=0; zero_in=0 -> pc_src=0.
- MEM_ALIGN_CHECK_EN defined, load addr 0x42 -> no dmem_req, misalign_err=1, reg_write_out=0, no stall.
